// File: rtl/reg_switch_pkg.sv
// reg_switch_pkg -- shared definitions for the reg_switch block.
//   `DATA_WIDTH : default channel word width (8).
//   MODE_RR     : mode encoding for round-robin arbitration.
//   MODE_FIXED  : mode encoding for fixed selection by S.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package reg_switch_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- stateless round-robin priority search.
// Ports:
//   req       : per-channel request vector (SIZE bits)
//   ptr       : index of the last granted channel; search starts at ptr+1
//   gnt_valid : high when at least one request is set
//   gnt_idx   : index of the first requesting channel at or after ptr+1 (with wrap)
module rr_arbiter #(
  parameter int SIZE      = 4,
  parameter int SEL_WIDTH = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]      req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 gnt_valid,
  output logic [SEL_WIDTH-1:0] gnt_idx
);

  int cand;

  // The last iteration (i == SIZE) revisits ptr itself, so it has lowest priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= SIZE; i++) begin
      cand = (int'(ptr) + i) % SIZE;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_switch.sv
// reg_switch -- N-to-1 registered switch with round-robin or fixed channel selection.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   mode        : 0 round-robin, 1 fixed select by S
//   S           : channel index used in fixed mode
//   in_valid    : per-channel word-present flags
//   data_in     : flattened channel words, channel n at [(n+1)*DATA_WIDTH-1 : n*DATA_WIDTH]
//   in_ready    : per-channel accept strobes (combinational, one-hot or zero)
//   out_valid   : output register holds a word
//   out_ready   : downstream accepts the held word
//   data_out    : registered output word
//   grant_idx   : channel the held word came from
module reg_switch
  import reg_switch_pkg::*;
#(
  parameter int   DATA_WIDTH = `DATA_WIDTH,
  parameter int   SIZE       = 4,
  localparam int  SEL_WIDTH  = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [SEL_WIDTH-1:0]       S,
  input  logic [SIZE-1:0]            in_valid,
  input  logic [SIZE*DATA_WIDTH-1:0] data_in,
  output logic [SIZE-1:0]            in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [SEL_WIDTH-1:0]       grant_idx
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic                 state_q;
  logic [SEL_WIDTH-1:0] ptr_q;
  logic [SIZE-1:0]      req;
  logic                 gnt_valid;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic                 accept;
  logic                 take;

  // Fixed mode funnels a single request into the same search, so the arbiter
  // grants S directly; an out-of-range S yields no request at all.
  always_comb begin
    req = '0;
    if (mode == MODE_FIXED) begin
      if (int'(S) < SIZE) begin
        req[S] = in_valid[S];
      end
    end else begin
      req = in_valid;
    end
  end

  rr_arbiter #(
    .SIZE      (SIZE),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Refill is allowed while draining so back-to-back words have no bubble.
  assign accept    = (state_q == ST_EMPTY) || out_ready;
  assign take      = accept && gnt_valid && !reset;
  assign out_valid = (state_q == ST_FULL);

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      data_out  <= '0;
      grant_idx <= '0;
      ptr_q     <= SEL_WIDTH'(SIZE - 1);
    end else if (take) begin
      state_q   <= ST_FULL;
      data_out  <= data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      grant_idx <= gnt_idx;
      ptr_q     <= gnt_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      // Drained with nothing to refill: data_out/grant_idx keep their last value.
      state_q <= ST_EMPTY;
    end
  end

endmodule

// File: doc/reg_switch.md
REG_SWITCH -- requirements
Module: reg_switch

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (8): width in bits of each channel word.
REQ-002 Parameter SIZE, default 4: number of input channels, legal range 2..16, need not be a power of two.
REQ-003 Localparam SEL_WIDTH = $clog2(SIZE): width of the select and grant fields.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: reset, synchronous and active-high.
REQ-006 mode  input  1: 0 = round-robin arbitration, 1 = fixed select by S.
REQ-007 S  input  SEL_WIDTH: channel index used when mode = 1.
REQ-008 in_valid  input  SIZE: per-channel word-present flags.
REQ-009 data_in  input  SIZE*DATA_WIDTH: flattened words; channel n occupies bits [(n+1)*DATA_WIDTH-1 : n*DATA_WIDTH].
REQ-010 in_ready  output  SIZE: per-channel accept strobes, combinational, at most one bit high.
REQ-011 out_valid  output  1: output register holds a word.
REQ-012 out_ready  input  1: downstream accepts the word this cycle.
REQ-013 data_out  output  DATA_WIDTH: registered output word.
REQ-014 grant_idx  output  SEL_WIDTH: registered index of the channel whose word is in data_out.

Function
REQ-015 Channel n transfers in a cycle when in_valid[n] and in_ready[n] are both high; downstream transfers when out_valid and out_ready are both high.
REQ-016 Two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 accept = EMPTY, or FULL with out_ready=1 (drain and refill in the same cycle); no bubble occurs at full throughput.
REQ-018 Eligible set: mode=0 -> all channels with in_valid high; mode=1 -> channel S only, if S < SIZE and in_valid[S] is high; S >= SIZE -> none.
REQ-019 Round-robin search starts at (ptr+1) mod SIZE, ascends with wrap, and grants the first eligible channel.
REQ-020 in_ready[g] = accept AND a grant exists; all other bits are 0; in_ready never depends on out_valid of the same channel.
REQ-021 On a channel transfer: data_out <= word of channel g, grant_idx <= g, FSM -> FULL, ptr <= g (in both modes).
REQ-022 On a downstream transfer with no simultaneous channel transfer: FSM -> EMPTY; data_out and grant_idx hold their last value.
REQ-023 While FULL and out_ready=0, data_out and grant_idx are stable and all in_ready bits are 0.
REQ-024 Latency from a channel transfer to out_valid is exactly 1 cycle.
REQ-025 Changes to mode or S take effect on the next arbitration only; a word already held is unaffected.
REQ-026 ptr is unchanged in cycles with no channel transfer.

Reset
REQ-027 reset=1 at a clock edge: FSM -> EMPTY, out_valid=0, data_out=0, grant_idx=0, ptr=SIZE-1 (first priority is channel 0).
REQ-028 reset has priority over all transfers in the same cycle; a word held mid-operation is discarded.
REQ-029 in_ready is all-zero while reset is high.

Structure
REQ-030 Mode encodings (MODE_RR=0, MODE_FIXED=1) and the DATA_WIDTH default live in the shared defines header; no other constants are shared.
REQ-031 Round-robin priority search is a separate combinational sub-module rr_arbiter (inputs: request vector, ptr; outputs: grant valid, grant index) with no state of its own.
REQ-032 ptr and the FSM register reside in reg_switch.

Verification
REQ-033 After reset, SIZE=4, mode=0, in_valid=4'b1111, out_ready=1 held -> grants 0,1,2,3,0 in consecutive cycles; out_valid high from cycle 2 onward.
REQ-034 mode=0, in_valid=4'b1010, out_ready=1 -> grant_idx alternates 1,3,1,3; in_ready[0] and in_ready[2] stay 0.
REQ-035 Channel 2 word 8'hA5 accepted, then out_ready=0 for 5 cycles while in_valid=4'b1111 -> data_out=8'hA5 and grant_idx=2 stable, in_ready=0; first grant after release is channel 3.
REQ-036 mode=1, S=2, in_valid=4'b0111 -> only channel 2 transfers each cycle; SIZE=3 with S=3 -> no grant and out_valid falls to 0 once drained.
REQ-037 reset pulsed while FULL with out_ready=0 -> next cycle out_valid=0, data_out=0, and the first grant afterwards is channel 0.
REQ-038 Random stimulus with a scoreboard -> every accepted word appears exactly once, in order, with the correct grant_idx, and no word is lost or duplicated.
